gf163_mul_seq: RTL and testbench
================================

GF163_MUL_SEQ -- requirements
Module: gf163_mul_seq

Interface
REQ-001 Parameter CORE_LAT, default 3, cycles from core_enable assertion to the cycle in which core_res is valid.
REQ-002 Parameter CNT_W, default 8, width of the squaring-count field.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset: synchronous, active-low.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_a, req_b  input  163 each  GF(2^163) operands, polynomial basis.
REQ-008 req_nsq  input  CNT_W  number of squarings applied after the initial product.
REQ-009 core_enable  output  1  single-cycle start pulse to the digit-serial multiplier core.
REQ-010 core_a, core_b  output  163 each  core operands, valid while core_enable=1.
REQ-011 core_res  input  163  core product, valid only in cycle issue+CORE_LAT.
REQ-012 res_valid  output  1  result held for the consumer.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_c  output  163  final result (A*B)^(2^nsq).
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, CAPT, DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; handshake req_valid&req_ready latches req_a, req_b, req_nsq; next state ISSUE.
REQ-018 ISSUE, one cycle: core_enable=1; core_a/core_b = latched operands (first pass) or, for squarings, both = working register W.
REQ-019 core_enable SHALL never be high for two consecutive cycles and SHALL stay 0 outside ISSUE; exactly one operation is in flight in the core.
REQ-020 WAIT: latency counter loaded with CORE_LAT-1 in ISSUE, decrements each cycle; at 1 -> CAPT.
REQ-021 CAPT is the cycle exactly CORE_LAT after ISSUE; W <= core_res at its end; core_res is not sampled in any other cycle.
REQ-022 CAPT -> ISSUE if remaining squarings > 0 (decrement), else -> DONE.
REQ-023 Per pass: 1 ISSUE + (CORE_LAT-1) WAIT + 1 CAPT = CORE_LAT+1 cycles; total latency from accept to res_valid = (nsq+1)*(CORE_LAT+1)+1 cycles (4-cycle pass, 5 cycles for nsq=0 at default).
REQ-024 DONE: res_valid=1, res_c=W, stable until res_valid&res_ready; then IDLE. No new request accepted in the handshake cycle itself.
REQ-025 req_nsq=0: single multiply, no squaring pass.
REQ-026 req_nsq=2^CNT_W-1: all passes executed; no counter wrap, no early exit.
REQ-027 req_valid while busy: ignored, inputs not sampled; request must be held until req_ready.
REQ-028 res_ready high outside DONE: no effect.
REQ-029 core_a/core_b SHALL be driven 0 when core_enable=0.

Reset
REQ-030 rst_n=0 at a rising edge: state IDLE, counters 0, W 0, res_valid 0, core_enable 0, busy 0, req_ready 1 from the following cycle.
REQ-031 Reset mid-operation aborts it; any in-flight core product is never captured; a request may be accepted on the first cycle after reset release and completes correctly.

Verification (bench uses a core model with CORE_LAT=3, field polynomial x^163+x^7+x^6+x^3+1)
REQ-032 A=163'h1, B=163'h2, nsq=0 -> core_enable one pulse; res_c=163'h2; res_valid exactly 5 cycles after accept.
REQ-033 A=163'h2, B=163'h2, nsq=2 -> 3 core pulses 4 cycles apart; res_c = x^8 = 163'h100; res_valid 13 cycles after accept.
REQ-034 A=B=x^162 (163'h4_0000...0), nsq=0 -> res_c = x^324 reduced, matches reference model; no core_res sampling outside CAPT.
REQ-035 Result held with res_ready=0 for 20 cycles while req_valid=1 -> res_c stable, req_ready=0, no core_enable; res_ready=1 -> IDLE, next request accepted the following cycle.
REQ-036 rst_n pulsed low during WAIT of nsq=5 op -> all outputs to reset values; new op A=163'h3, B=163'h3, nsq=0 -> res_c=163'h5.
REQ-037 Random 1000 ops, nsq 0..8, random res_ready -> every res_c equals model; core_enable never high two cycles in a row.

Source files
------------

// File: rtl/gf163_mul_seq_if.sv
// gf163_mul_seq_if: request, multiplier-core and result signals of the GF(2^163) sequencer
interface gf163_mul_seq_if #(
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [162:0]     req_a;
    logic [162:0]     req_b;
    logic [CNT_W-1:0] req_nsq;
    logic             core_enable;
    logic [162:0]     core_a;
    logic [162:0]     core_b;
    logic [162:0]     core_res;
    logic             res_valid;
    logic             res_ready;
    logic [162:0]     res_c;
    logic             busy;

    modport slave (
        input  req_valid, req_a, req_b, req_nsq, core_res, res_ready,
        output req_ready, core_enable, core_a, core_b, res_valid, res_c, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_nsq, core_res, res_ready,
        input  req_ready, core_enable, core_a, core_b, res_valid, res_c, busy
    );
endinterface

// File: rtl/gf163_mul_seq.sv
// gf163_mul_seq: computes (A*B)^(2^nsq) by sequencing one product and nsq squarings on an external core
module gf163_mul_seq #(
    parameter int CORE_LAT = 3,
    parameter int CNT_W    = 8
) (
    input logic            clk,
    input logic            rst_n,
    gf163_mul_seq_if.slave bus
);
    localparam int LW = (CORE_LAT > 2) ? $clog2(CORE_LAT) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(CORE_LAT - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [162:0]     r_a;
    logic [162:0]     r_b;
    logic [162:0]     r_w;
    logic [CNT_W-1:0] r_nsq;
    logic [LW-1:0]    r_lat;
    logic             r_first;
    logic             w_issue;

    // Sequencer: one pass per core operation, the core result is taken only in CAPT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_w     <= '0;
            r_nsq   <= '0;
            r_lat   <= '0;
            r_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_nsq   <= bus.req_nsq;
                        r_first <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_lat   <= LAT_LOAD;
                    r_state <= (CORE_LAT == 1) ? S_CAPT : S_WAIT;
                end
                S_WAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == LW'(1))
                        r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_w     <= bus.core_res;
                    r_first <= 1'b0;
                    if (r_nsq != '0) begin
                        r_nsq   <= r_nsq - 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The first pass multiplies the latched operands, every later pass squares W
    assign w_issue         = (r_state == S_ISSUE);
    assign bus.core_enable = w_issue;
    assign bus.core_a      = w_issue ? (r_first ? r_a : r_w) : '0;
    assign bus.core_b      = w_issue ? (r_first ? r_b : r_w) : '0;
    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.res_c       = r_w;
endmodule

// File: tb/tb_gf163_mul_seq.sv
// tb_gf163_mul_seq: random and directed checks of the GF(2^163) sequencer against a field-arithmetic model
module tb_gf163_mul_seq;
    localparam int CL = 3;
    localparam logic [163:0] POLY = (164'd1 << 163) | 164'hC9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf163_mul_seq_if #(.CNT_W(8)) bus();
    gf163_mul_seq #(.CORE_LAT(CL), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_dbl = 0;
    int n_nz = 0;
    logic prev_en = 1'b0;
    int en_cyc[$];
    logic [CL-1:0] pipe_v = '0;
    logic [162:0] pipe_p [CL];
    logic [162:0] garbage = '0;

    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [325:0] p;
        p = '0;
        for (int i = 0; i < 163; i++)
            if (b[i]) p = p ^ (326'(a) << i);
        for (int i = 324; i >= 163; i--)
            if (p[i]) p = p ^ (326'(POLY) << (i - 163));
        return p[162:0];
    endfunction

    function automatic logic [162:0] model(input logic [162:0] a, input logic [162:0] b, input int nsq);
        logic [162:0] w;
        w = gf_mul(a, b);
        for (int i = 0; i < nsq; i++) w = gf_mul(w, w);
        return w;
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[162:0];
    endfunction

    // Multiplier core: product appears exactly CL cycles after the enable, random junk otherwise
    always @(posedge clk) begin
        pipe_v[0] <= bus.core_enable;
        if (bus.core_enable) pipe_p[0] <= gf_mul(bus.core_a, bus.core_b);
        for (int i = 1; i < CL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_p[i] <= pipe_p[i-1];
        end
        garbage <= rnd163();
        cyc <= cyc + 1;
    end
    assign bus.core_res = pipe_v[CL-1] ? pipe_p[CL-1] : garbage;

    // Protocol watch on the core port: no back-to-back enables, zero operands when idle
    always @(negedge clk) begin
        if (bus.core_enable && prev_en) n_dbl <= n_dbl + 1;
        if (!bus.core_enable && (bus.core_a != '0 || bus.core_b != '0)) n_nz <= n_nz + 1;
        if (bus.core_enable) en_cyc.push_back(cyc);
        prev_en <= bus.core_enable;
    end

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue_req(input logic [162:0] a, input logic [162:0] b, input logic [7:0] nsq);
        int k;
        k = 0;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_nsq = nsq;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 163'(bus.req_ready), 163'd1);
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input logic [162:0] exp, input bit keep);
        int k;
        k = 0;
        while (k < 5000) begin
            @(negedge clk);
            k++;
            if (k == 1 && !keep) bus.req_valid = 1'b0;
            if (bus.res_valid) break;
            bus.res_ready = 1'($urandom_range(0, 1));
        end
        bus.res_ready = 1'b0;
        check({tag, "_lat"}, 163'(k), 163'(exp_lat));
        check({tag, "_res"}, bus.res_c, exp);
    endtask

    task automatic hold_release(input int n);
        logic [162:0] c0;
        int bad;
        c0 = bus.res_c;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.res_c !== c0 || !bus.res_valid || bus.req_ready || bus.core_enable) bad++;
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("hold_stable", 163'(bad), 163'd0);
        check("idle_after_ack", 163'({bus.req_ready, bus.res_valid}), 163'd2);
    endtask

    initial begin
        logic [162:0] a;
        logic [162:0] b;
        int nsq;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_nsq = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 163'({bus.req_ready, bus.busy, bus.res_valid, bus.core_enable}), 163'b1000);
        check("rst_res_c", bus.res_c, 163'd0);
        rst_n = 1'b1;

        issue_req(163'h1, 163'h2, 8'd0);
        en_cyc.delete();
        wait_result("one_x", 5, 163'h2, 1'b0);
        check("one_x_pulses", 163'(en_cyc.size()), 163'd1);
        hold_release(0);

        issue_req(163'h2, 163'h2, 8'd2);
        en_cyc.delete();
        wait_result("sq2", 13, 163'h100, 1'b0);
        check("sq2_pulses", 163'(en_cyc.size()), 163'd3);
        if (en_cyc.size() == 3) begin
            check("sq2_gap1", 163'(en_cyc[1] - en_cyc[0]), 163'd4);
            check("sq2_gap2", 163'(en_cyc[2] - en_cyc[1]), 163'd4);
        end
        hold_release(1);

        a = 163'd1 << 162;
        issue_req(a, a, 8'd0);
        wait_result("top_bit", 5, model(a, a, 0), 1'b0);
        hold_release(2);

        issue_req(163'h7, 163'h9, 8'd0);
        wait_result("hold", 5, model(163'h7, 163'h9, 0), 1'b1);
        bus.req_a = 163'h3;
        bus.req_b = 163'h3;
        bus.req_nsq = 8'd0;
        hold_release(20);
        wait_result("after_hold", 5, 163'h5, 1'b0);
        hold_release(0);

        issue_req(163'h1234, 163'h5678, 8'd5);
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", 163'({bus.req_ready, bus.busy, bus.res_valid, bus.core_enable}), 163'b1000);
        check("midrst_res_c", bus.res_c, 163'd0);
        rst_n = 1'b1;
        issue_req(163'h3, 163'h3, 8'd0);
        wait_result("post_rst", 5, 163'h5, 1'b0);
        hold_release(0);

        a = rnd163();
        b = rnd163();
        issue_req(a, b, 8'd255);
        wait_result("nsq_max", 256 * (CL + 1) + 1, model(a, b, 255), 1'b0);
        hold_release(1);

        for (int i = 0; i < 1000; i++) begin
            a = rnd163();
            b = ($urandom_range(0, 9) == 0) ? (163'd1 << 162) : rnd163();
            nsq = $urandom_range(0, 8);
            issue_req(a, b, 8'(nsq));
            wait_result("rnd", (nsq + 1) * (CL + 1) + 1, model(a, b, nsq), 1'b0);
            hold_release($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                bus.res_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.res_ready = 1'b0;
        end

        check("no_double_enable", 163'(n_dbl), 163'd0);
        check("core_ops_zero_idle", 163'(n_nz), 163'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
